// File: rtl/updown_counter_pkg.sv
// Shared definitions for the up/down counter: the wrap/saturate mode encoding.
package updown_counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

endpackage

// File: rtl/updown_counter_nextval.sv
// Combinational next-count and boundary-crossing computation.
// All comparisons run one bit wider than the widest operand, so a sum such as
// 14+15 is seen as 29 (past the bound) rather than an aliased 13.
module updown_counter_nextval
    import updown_counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  count,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lo_bound,
    input  logic [WIDTH-1:0]  hi_bound,
    input  logic              dir,
    input  logic              mode,
    output logic [WIDTH-1:0]  next,
    output logic              cross_up,
    output logic              cross_dn
);

    localparam int EW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;

    logic [EW-1:0] cnt_e;
    logic [EW-1:0] step_e;
    logic [EW-1:0] lo_e;
    logic [EW-1:0] hi_e;
    logic [EW-1:0] sum_e;
    logic [EW-1:0] floor_e;
    logic          in_range;

    assign cnt_e    = EW'(count);
    assign step_e   = EW'(step);
    assign lo_e     = EW'(lo_bound);
    assign hi_e     = EW'(hi_bound);
    assign sum_e    = cnt_e + step_e;
    assign floor_e  = lo_e + step_e;
    assign in_range = (count >= lo_bound) && (count <= hi_bound);

    // Next value: zero step holds, out-of-range restarts at lo_bound, else step or cross.
    always_comb begin
        next     = count;
        cross_up = 1'b0;
        cross_dn = 1'b0;
        if (step_e != '0) begin
            if (!in_range) begin
                next = lo_bound;
            end else if (dir) begin
                if (sum_e <= hi_e) begin
                    next = WIDTH'(sum_e);
                end else begin
                    cross_up = 1'b1;
                    next     = (mode == MODE_SAT) ? hi_bound : lo_bound;
                end
            end else begin
                if (cnt_e >= floor_e) begin
                    next = WIDTH'(cnt_e - step_e);
                end else begin
                    cross_dn = 1'b1;
                    next     = (mode == MODE_SAT) ? lo_bound : hi_bound;
                end
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Bounded up/down counter with wrap/saturate modes, synchronous clamped load,
// a registered terminal-count pulse and sticky overflow/underflow flags.
// A bad configuration (lo_bound > hi_bound) freezes count and flags.
module updown_counter_param
    import updown_counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up_down,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lo_bound,
    input  logic [WIDTH-1:0]  hi_bound,
    input  logic              mode,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  count,
    output logic              at_max,
    output logic              at_min,
    output logic              tc,
    output logic              ovf,
    output logic              unf,
    output logic              cfg_err
);

    logic [WIDTH-1:0] next_val;
    logic             cross_up;
    logic             cross_dn;
    logic [WIDTH-1:0] load_clamped;
    logic             set_ovf;
    logic             set_unf;

    updown_counter_nextval #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_nextval (
        .count    (count),
        .step     (step),
        .lo_bound (lo_bound),
        .hi_bound (hi_bound),
        .dir      (up_down),
        .mode     (mode),
        .next     (next_val),
        .cross_up (cross_up),
        .cross_dn (cross_dn)
    );

    assign cfg_err = (lo_bound > hi_bound);
    assign at_max  = (count == hi_bound);
    assign at_min  = (count == lo_bound);

    // Events only come from an enabled count step (load never raises one).
    assign set_ovf = en && !load && cross_up;
    assign set_unf = en && !load && cross_dn;

    // Clamp the load value into the inclusive range.
    always_comb begin
        load_clamped = load_val;
        if (load_val < lo_bound) begin
            load_clamped = lo_bound;
        end else if (load_val > hi_bound) begin
            load_clamped = hi_bound;
        end
    end

    // Count, terminal-count pulse and sticky flags; set beats clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (cfg_err) begin
            tc <= 1'b0;
        end else begin
            if (load) begin
                count <= load_clamped;
                tc    <= 1'b0;
            end else if (en) begin
                count <= next_val;
                tc    <= cross_up || cross_dn;
            end else begin
                tc <= 1'b0;
            end

            if (set_ovf) begin
                ovf <= 1'b1;
            end else if (clr_flags) begin
                ovf <= 1'b0;
            end

            if (set_unf) begin
                unf <= 1'b1;
            end else if (clr_flags) begin
                unf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: directed scenarios plus random traffic,
// checked against an integer reference model through an expected queue.
module tb_updown_counter_param;

    localparam int W  = 4;
    localparam int SW = 4;
    localparam int XW = W + 6;

    logic          clk;
    logic          reset;
    logic          en;
    logic          up_down;
    logic          load;
    logic [W-1:0]  load_val;
    logic [SW-1:0] step;
    logic [W-1:0]  lo_bound;
    logic [W-1:0]  hi_bound;
    logic          mode;
    logic          clr_flags;
    logic [W-1:0]  count;
    logic          at_max;
    logic          at_min;
    logic          tc;
    logic          ovf;
    logic          unf;
    logic          cfg_err;

    updown_counter_param #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .up_down   (up_down),
        .load      (load),
        .load_val  (load_val),
        .step      (step),
        .lo_bound  (lo_bound),
        .hi_bound  (hi_bound),
        .mode      (mode),
        .clr_flags (clr_flags),
        .count     (count),
        .at_max    (at_max),
        .at_min    (at_min),
        .tc        (tc),
        .ovf       (ovf),
        .unf       (unf),
        .cfg_err   (cfg_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [XW-1:0] exp_q[$];
    string         name_q[$];
    int            n_checks = 0;
    int            n_errors = 0;

    // reference model state
    int m_count = 0;
    bit m_tc    = 0;
    bit m_ovf   = 0;
    bit m_unf   = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Apply the counter rules to one clock edge using plain integers.
    task automatic model_edge(input bit rst, input bit e, input bit ud, input bit ld,
                              input int lv, input int st, input int lo, input int hi,
                              input bit md, input bit clr);
        bit ev_up;
        bit ev_dn;
        ev_up = 0;
        ev_dn = 0;
        if (!rst) begin
            m_count = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
        end else if (lo > hi) begin
            m_tc = 0;
        end else begin
            m_tc = 0;
            if (ld) begin
                m_count = (lv < lo) ? lo : ((lv > hi) ? hi : lv);
            end else if (e && st != 0) begin
                if (m_count < lo || m_count > hi) begin
                    m_count = lo;
                end else if (ud) begin
                    if (m_count + st <= hi) m_count = m_count + st;
                    else begin ev_up = 1; m_count = md ? hi : lo; end
                end else begin
                    if (m_count - st >= lo) m_count = m_count - st;
                    else begin ev_dn = 1; m_count = md ? lo : hi; end
                end
            end
            m_tc = ev_up || ev_dn;
            if (ev_up) m_ovf = 1; else if (clr) m_ovf = 0;
            if (ev_dn) m_unf = 1; else if (clr) m_unf = 0;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input string nm, input bit rst, input bit e, input bit ud,
                         input bit ld, input int lv, input int st, input int lo,
                         input int hi, input bit md, input bit clr);
        logic [XW-1:0] x;
        @(negedge clk);
        reset     = rst;
        en        = e;
        up_down   = ud;
        load      = ld;
        load_val  = W'(lv);
        step      = SW'(st);
        lo_bound  = W'(lo);
        hi_bound  = W'(hi);
        mode      = md;
        clr_flags = clr;
        model_edge(rst, e, ud, ld, lv, st, lo, hi, md, clr);
        x = {W'(m_count), m_tc, m_ovf, m_unf,
             (m_count == hi), (m_count == lo), (lo > hi)};
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [XW-1:0] got;
        logic [XW-1:0] want;
        string         nm;
        #1;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            got  = {count, tc, ovf, unf, at_max, at_min, cfg_err};
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL %s: got {count,tc,ovf,unf,at_max,at_min,cfg_err}=%b expected %b",
                         nm, got, want);
            end
        end
    end

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; en = 1'b0; up_down = 1'b0; load = 1'b0; load_val = '0;
        step = '0; lo_bound = '0; hi_bound = 4'd15; mode = 1'b0; clr_flags = 1'b0;

        // reset state
        drive("reset_hold", 0, 0, 0, 0, 0, 0, 0, 15, 0, 0);
        drive("reset_hold2", 0, 1, 1, 0, 0, 1, 0, 15, 0, 0);
        drive("reset_release", 1, 0, 0, 0, 0, 0, 0, 15, 0, 0);

        // wrap up: 2,5,8,2
        drive("s1_load", 1, 0, 1, 1, 2, 3, 2, 9, 0, 0);
        drive("s1_up5", 1, 1, 1, 0, 0, 3, 2, 9, 0, 0);
        drive("s1_up8", 1, 1, 1, 0, 0, 3, 2, 9, 0, 0);
        drive("s1_wrap", 1, 1, 1, 0, 0, 3, 2, 9, 0, 0);
        settle();
        chk("s1_count", count, 2);
        chk("s1_tc", tc, 1);
        chk("s1_ovf", ovf, 1);
        drive("s1_tc_drop", 1, 0, 1, 0, 0, 3, 2, 9, 0, 0);

        // async reset mid-count: load 7 with ovf still set
        drive("s4_load7", 1, 0, 1, 1, 7, 3, 2, 9, 0, 0);
        settle();
        chk("s4_pre_count", count, 7);
        chk("s4_pre_ovf", ovf, 1);
        reset = 1'b0;
        #1;
        chk("s4_async_count", count, 0);
        chk("s4_async_ovf", ovf, 0);
        model_edge(0, 0, 0, 0, 0, 0, 2, 9, 0, 0);
        drive("s4_hold1", 0, 1, 1, 0, 0, 3, 2, 9, 0, 0);
        drive("s4_hold2", 0, 1, 1, 0, 0, 3, 2, 9, 0, 0);
        drive("s4_release", 1, 0, 1, 0, 0, 3, 2, 9, 0, 0);
        settle();
        chk("s4_stays0", count, 0);

        // saturate down: 12 -> 8,4,3,3
        drive("s2_load", 1, 0, 0, 1, 12, 4, 3, 12, 1, 0);
        drive("s2_dn8", 1, 1, 0, 0, 0, 4, 3, 12, 1, 0);
        drive("s2_dn4", 1, 1, 0, 0, 0, 4, 3, 12, 1, 0);
        drive("s2_sat3", 1, 1, 0, 0, 0, 4, 3, 12, 1, 0);
        drive("s2_sat3b", 1, 1, 0, 0, 0, 4, 3, 12, 1, 0);
        settle();
        chk("s2_count", count, 3);
        chk("s2_tc", tc, 1);
        chk("s2_unf", unf, 1);
        chk("s2_at_min", at_min, 1);

        // load clamp and priority over en
        drive("s3_clamp_hi", 1, 1, 1, 1, 14, 1, 4, 10, 0, 0);
        settle();
        chk("s3_count10", count, 10);
        chk("s3_no_tc", tc, 0);
        drive("s3_clamp_lo", 1, 1, 1, 1, 1, 1, 4, 10, 0, 0);
        settle();
        chk("s3_count4", count, 4);

        // step 0 holds, out-of-range restarts at lo, lo==hi always crosses
        drive("step0_hold", 1, 1, 1, 0, 0, 0, 4, 10, 0, 0);
        drive("oor_to_lo", 1, 1, 0, 0, 0, 2, 6, 10, 0, 0);
        drive("eq_bounds", 1, 1, 1, 0, 0, 1, 6, 6, 0, 0);

        // flags: clear alone, then clear coincident with overflow
        drive("clr_alone", 1, 0, 1, 0, 0, 1, 2, 9, 0, 1);
        settle();
        chk("clr_ovf", ovf, 0);
        drive("s5_load9", 1, 0, 1, 1, 9, 1, 2, 9, 0, 0);
        drive("s5_set_wins", 1, 1, 1, 0, 0, 1, 2, 9, 0, 1);
        settle();
        chk("s5_ovf", ovf, 1);
        drive("s5_cfg_en", 1, 1, 1, 0, 0, 1, 9, 5, 0, 0);
        drive("s5_cfg_load", 1, 1, 1, 1, 7, 1, 9, 5, 0, 1);
        settle();
        chk("s5_cfg_err", cfg_err, 1);
        chk("s5_hold_count", count, 2);

        // edge widths: 14+15 must cross, not alias to 13
        drive("s6_load14", 1, 0, 1, 1, 14, 15, 1, 15, 0, 0);
        drive("s6_cross", 1, 1, 1, 0, 0, 15, 1, 15, 0, 0);
        settle();
        chk("s6_count", count, 1);
        chk("s6_tc", tc, 1);

        // random traffic
        begin
            int lo_r = 2;
            int hi_r = 13;
            bit md_r = 0;
            for (int i = 0; i < 400; i++) begin
                int lv;
                int st;
                if ($urandom_range(0, 24) == 0) begin
                    lo_r = $urandom_range(0, 15);
                    hi_r = $urandom_range(0, 15);
                    md_r = 1'($urandom_range(0, 1));
                end
                lv = $urandom_range(0, 15);
                st = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
                drive("random", 1, ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) == 0), lv, st, lo_r, hi_r, md_r,
                      ($urandom_range(0, 9) == 0));
            end
        end

        // drain
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // time limit
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
